serial_lane_receiver: RTL and testbench
=======================================

# serial_lane_receiver

Single-clock, bit-serial lane receiver: samples one serial bit per `clk`, applies lane polarity, and assembles `DWIDTH`-bit parallel words with a word-boundary bit-slip mechanism. It is the receiving counterpart of the per-lane serializer in the behavioral SerDes layer. It sits between a lane's serial RX wire and the link layer's `phy_data_rx_phy2link` slice. The link-layer training logic drives `bit_slip` and `lane_polarity` to achieve word alignment.

## Interface
Parameters:
- `DWIDTH`, default 32: parallel word width per lane (LANE_WIDTH); legal range 2–256.
- `SLIP_HOLDOFF`, default 4: number of words after an executed slip during which further slip requests are dropped; legal range 1–255.

Ports:
- `clk`  in  1  sample clock; one serial bit per rising edge.
- `res`  in  1  reset; asynchronous, active-high.
- `serial_in`  in  1  serial lane bit, LSB of word first.
- `lane_polarity`  in  1  1 = invert every sampled bit; quasi-static.
- `bit_slip`  in  1  single-cycle slip request pulse.
- `data_out`  out  DWIDTH  last completed word.
- `data_valid`  out  1  one-cycle strobe when `data_out` updates.
- `slip_ack`  out  1  one-cycle pulse when a slip is executed.
- `slip_count`  out  8  executed-slip counter; present only with `SERIAL_LANE_RX_SLIP_STAT_EN`.

## Operation
- Sampled bit: `b = serial_in ^ lane_polarity`. `b` is shifted into the assembly register at bit position `bit_cnt`, so the first bit received goes to `data_out[0]`.
- `bit_cnt` runs 0..DWIDTH-1 and wraps. On a sample with `bit_cnt == DWIDTH-1`:
  - the completed word (shift register plus current `b`) is loaded into `data_out`;
  - `data_valid` = 1 for one cycle.
- State machine, encoding `IDLE` / `PENDING` / `SLIP` / `HOLDOFF`:
  - IDLE: `bit_slip` = 1 → PENDING.
  - PENDING: at the word-completion sample → SLIP. The word is still output normally.
  - SLIP (exactly one cycle):
    - the sampled bit is discarded and `bit_cnt` is held at 0;
    - `slip_ack` = 1;
    - holdoff word counter loads `SLIP_HOLDOFF`;
    - → HOLDOFF.
  - HOLDOFF: decrement the holdoff counter on each `data_valid`; at 0 → IDLE.
- `bit_slip` in PENDING, SLIP or HOLDOFF is dropped. It is not queued.
- Net effect of one slip: the word boundary moves one bit later, so the output word is the original rotated right by one.
- `bit_slip` coinciding with a completion sample while in IDLE → PENDING. The slip executes at the *next* completion, not the current one.
- A `lane_polarity` change takes effect on the next sample. There is no resync.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `slip_ack` = 0, `slip_count` = 0;
  - state = IDLE, `bit_cnt` = 0, shift register = 0.
- The first sample is the first rising edge with `res` low. The first `data_valid` is seen after edge DWIDTH-1; steady state is one word every DWIDTH cycles.
- Word latency: the last bit is sampled at edge N and the word is visible on `data_out` / `data_valid` after edge N.
- A slip executes on the edge immediately after a completion edge. The next completion then comes DWIDTH+1 edges after the previous one.
- Reset asserted mid-word: all state clears immediately (async) and the partial word is lost. Counting restarts at 0 after release.

## Configuration
- `SERIAL_LANE_RX_SLIP_STAT_EN` defined:
  - `slip_count` port exists;
  - it increments on each `slip_ack`, saturates at 255, and clears only on `res`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `serial_lane_rx_pkg`:
  - state enum `slrx_state_t` (IDLE, PENDING, SLIP, HOLDOFF);
  - constant `SLRX_SLIP_CNT_W = 8`.
- One sub-module is natural: `serial_lane_rx_slip_ctrl`. It holds the FSM and holdoff counter, takes the completion strobe and `bit_slip`, and produces the hold-bit enable and `slip_ack`.
- The datapath (shift register, `bit_cnt`, output registers) stays in the top.

## Test plan
All scenarios use DWIDTH=8 and SLIP_HOLDOFF=4.
- Repeated 0xA5 sent LSB-first, polarity 0 → `data_out` = 0xA5, `data_valid` every 8 cycles; first strobe after edge 7.
- Same stream with `lane_polarity` = 1 → `data_out` = 0x5A.
- 0xA5 stream, one `bit_slip` pulse:
  - one `slip_ack`;
  - the gap between the two strobes around the slip is 9 cycles;
  - subsequent words are 0xD2.
- Eight slips, each issued after its holdoff expires → the word sequence ends back at 0xA5. With the macro defined, `slip_count` = 8.
- Second `bit_slip` 2 words after an ack (inside holdoff) → no `slip_ack`, word unchanged.
- `res` pulsed at edge 5 of a word → `data_out` = 0 and `data_valid` = 0 immediately; the next strobe comes 8 edges after release.

Source files
------------

// File: rtl/serial_lane_rx_pkg.sv
// Shared types and constants for the serial lane receiver and its slip controller.
package serial_lane_rx_pkg;

   localparam int unsigned SLRX_SLIP_CNT_W = 8;
   localparam int unsigned SLRX_HOLD_W     = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SLIP    = 2'd2,
      HOLDOFF = 2'd3
   } slrx_state_t;

endpackage

// File: rtl/serial_lane_rx_slip_ctrl.sv
// Bit-slip sequencer: arms on a request, executes one bit-discard cycle after the
// next word completion, then ignores requests for SLIP_HOLDOFF completed words.
module serial_lane_rx_slip_ctrl
   import serial_lane_rx_pkg::*;
#(
   parameter int unsigned SLIP_HOLDOFF = 4
) (
   input  logic clk,
   input  logic res,
   input  logic complete,
   input  logic bit_slip,
   output logic hold_c,
   output logic slip_ack
);

   slrx_state_t            state;
   logic [SLRX_HOLD_W-1:0] holdoff;

   // The discard cycle is the single cycle spent in SLIP.
   assign hold_c = (state == SLIP);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state    <= IDLE;
         holdoff  <= '0;
         slip_ack <= 1'b0;
      end else begin
         slip_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bit_slip) state <= PENDING;
            end
            PENDING: begin
               if (complete) state <= SLIP;
            end
            SLIP: begin
               slip_ack <= 1'b1;
               holdoff  <= SLRX_HOLD_W'(SLIP_HOLDOFF);
               state    <= HOLDOFF;
            end
            HOLDOFF: begin
               if (complete) begin
                  if (holdoff <= SLRX_HOLD_W'(1)) begin
                     holdoff <= '0;
                     state   <= IDLE;
                  end else begin
                     holdoff <= holdoff - SLRX_HOLD_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_lane_receiver.sv
// Bit-serial lane receiver: polarity correction, LSB-first word assembly and bit slip.
// Optional slip statistics counter enabled by SERIAL_LANE_RX_SLIP_STAT_EN.
module serial_lane_receiver
   import serial_lane_rx_pkg::*;
#(
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned SLIP_HOLDOFF = 4
) (
   input  logic              clk,
   input  logic              res,
   input  logic              serial_in,
   input  logic              lane_polarity,
   input  logic              bit_slip,
   output logic [DWIDTH-1:0] data_out,
   output logic              data_valid,
   output logic              slip_ack
`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
   ,
   output logic [SLRX_SLIP_CNT_W-1:0] slip_count
`endif
);

   localparam int unsigned     CNT_W    = $clog2(DWIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

   logic [CNT_W-1:0]  bit_cnt;
   logic [DWIDTH-1:0] sr;
   logic [DWIDTH-1:0] word_c;
   logic              b_c;
   logic              hold_c;
   logic              complete_c;

   assign b_c        = serial_in ^ lane_polarity;
   assign complete_c = !hold_c && (bit_cnt == LAST_BIT);

   // Final bit goes straight to the output word, bypassing the assembly register.
   always_comb begin
      word_c             = sr;
      word_c[DWIDTH-1]   = b_c;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         bit_cnt    <= '0;
         sr         <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (hold_c) begin
            bit_cnt <= '0;
         end else begin
            sr[bit_cnt] <= b_c;
            if (complete_c) begin
               data_out   <= word_c;
               data_valid <= 1'b1;
               bit_cnt    <= '0;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   serial_lane_rx_slip_ctrl #(
      .SLIP_HOLDOFF (SLIP_HOLDOFF)
   ) u_slip_ctrl (
      .clk      (clk),
      .res      (res),
      .complete (complete_c),
      .bit_slip (bit_slip),
      .hold_c   (hold_c),
      .slip_ack (slip_ack)
   );

`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
   // Saturating count of executed slips, cleared only by reset.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         slip_count <= '0;
      end else if (slip_ack && (slip_count != '1)) begin
         slip_count <= slip_count + SLRX_SLIP_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_serial_lane_receiver.sv
// Directed scoreboard bench for serial_lane_receiver (DWIDTH=8, SLIP_HOLDOFF=4).
module tb_serial_lane_receiver;

   localparam int unsigned DW = 8;
   localparam int unsigned HO = 4;

   typedef struct {
      logic [7:0] word;
      int         gap;
   } exp_t;

   logic          clk = 1'b0;
   logic          res;
   logic          serial_in;
   logic          lane_polarity;
   logic          bit_slip;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          slip_ack;
`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
   logic [7:0]    slip_count;
`endif

   int         tests   = 0;
   int         fails   = 0;
   int         ecount  = -1;
   int         last    = -1;
   int         strobes = 0;
   int         acks    = 0;
   int         rot     = 0;
   logic [7:0] pat     = 8'hA5;
   logic [2:0] ph      = 3'd0;
   exp_t       q[$];

   always #5 clk = ~clk;

   serial_lane_receiver #(
      .DWIDTH       (DW),
      .SLIP_HOLDOFF (HO)
   ) dut (
      .clk           (clk),
      .res           (res),
      .serial_in     (serial_in),
      .lane_polarity (lane_polarity),
      .bit_slip      (bit_slip),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .slip_ack      (slip_ack)
`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
      ,
      .slip_count    (slip_count)
`endif
   );

   function automatic logic [7:0] rotr8(input logic [7:0] v, input int k);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < (k % 8); i++) r = {r[0], r[7:1]};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [7:0] w, input int g);
      exp_t e;
      e.word = w;
      e.gap  = g;
      q.push_back(e);
   endtask

   // One serial bit per edge; outputs sampled 1 time unit after the edge.
   task automatic step(input logic slip);
      exp_t e;
      serial_in = pat[ph];
      bit_slip  = slip;
      @(posedge clk);
      #1;
      bit_slip = 1'b0;
      ph       = ph + 3'd1;
      ecount++;
      if (slip_ack) acks++;
      if (data_valid) begin
         strobes++;
         check("strobe_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("word", 32'(data_out), 32'(e.word));
            check("gap", 32'(ecount - last), 32'(e.gap));
         end
         last = ecount;
      end
   endtask

   task automatic wait_strobes(input int n);
      int start;
      int budget;
      start  = strobes;
      budget = 0;
      while ((strobes - start) < n && budget < 40 * n) begin
         step(1'b0);
         budget++;
      end
      check("strobe_count", 32'(strobes - start), 32'(n));
   endtask

   initial begin
      res           = 1'b1;
      serial_in     = 1'b0;
      lane_polarity = 1'b0;
      bit_slip      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_slip_ack", 32'(slip_ack), 32'd0);
`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
      check("rst_slip_count", 32'(slip_count), 32'd0);
`endif
      res = 1'b0;

      // Plain 0xA5 stream; first strobe lands on edge 7.
      repeat (4) push(8'hA5, 8);
      wait_strobes(4);

      // Inverted lane.
      lane_polarity = 1'b1;
      repeat (2) push(8'h5A, 8);
      wait_strobes(2);
      lane_polarity = 1'b0;

      // One slip requested mid-word; executes after this word completes.
      push(8'hA5, 8);
      push(8'hD2, 9);
      push(8'hD2, 8);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      wait_strobes(1);
      check("ack_before_exec", 32'(acks), 32'd0);
      wait_strobes(2);
      check("ack_after_slip", 32'(acks), 32'd1);
      rot = 1;

      // Request inside holdoff must be dropped.
      push(8'hD2, 8);
      push(8'hD2, 8);
      step(1'b1);
      wait_strobes(2);
      check("ack_dropped", 32'(acks), 32'd1);

      // Seven more slips, each after holdoff expires, rotating back to 0xA5.
      for (int k = 2; k <= 8; k++) begin
         push(rotr8(pat, k - 1), 8);
         push(rotr8(pat, k), 9);
         repeat (HO - 1) push(rotr8(pat, k), 8);
         step(1'b1);
         wait_strobes(1 + int'(HO));
         rot = k;
         check("ack_count", 32'(acks), 32'(k));
      end
      check("final_word", 32'(data_out), 32'(rotr8(pat, rot)));
      check("final_word_a5", 32'(data_out), 32'hA5);
`ifdef SERIAL_LANE_RX_SLIP_STAT_EN
      step(1'b0);
      check("slip_count", 32'(slip_count), 32'd8);
      repeat (4) step(1'b0);
`else
      repeat (5) step(1'b0);
`endif

      // Reset after edge 5 of a word: outputs clear at once.
      res = 1'b1;
      #1;
      check("midrst_data_out", 32'(data_out), 32'd0);
      check("midrst_data_valid", 32'(data_valid), 32'd0);
      check("midrst_slip_ack", 32'(slip_ack), 32'd0);
      @(posedge clk);
      #1;
      res = 1'b0;
      q.delete();
      ecount = -1;
      last   = -1;
      ph     = 3'd0;
      repeat (2) push(8'hA5, 8);
      wait_strobes(2);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
